// File: rtl/argmax_classifier.sv
// Sequential argmax over one vector of signed logits, one compare per clock.
// Optional macro ARGMAX_MARGIN_EN adds margin_o (best minus second best).
module argmax_classifier #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 16,
  parameter int N_NEURONS  = 10,
  localparam int IDX_WIDTH = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic signed [DATA_WIDTH-1:0] logits_i [N_NEURONS],
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic        [IDX_WIDTH-1:0]  class_o,
  output logic signed [DATA_WIDTH-1:0] max_logit_o,
`ifdef ARGMAX_MARGIN_EN
  output logic signed [DATA_WIDTH-1:0] margin_o,
`endif
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
);

  if (N_NEURONS < 1) begin : g_n_chk
    $error("N_NEURONS must be at least 1");
  end
  if (FRAC_WIDTH > DATA_WIDTH) begin : g_frac_chk
    $error("FRAC_WIDTH must not exceed DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  localparam logic [IDX_WIDTH-1:0] LAST =
    IDX_WIDTH'(N_NEURONS - 1);
  localparam logic signed [DATA_WIDTH-1:0] MAXV =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MINV =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] cap_q [N_NEURONS];
  logic signed [DATA_WIDTH-1:0] cap_d [N_NEURONS];
  logic signed [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic        [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
  logic        [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] cur;
`ifdef ARGMAX_MARGIN_EN
  logic signed [DATA_WIDTH-1:0] second_q, second_d;
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [DATA_WIDTH-1:0] sat;
`endif

  // Next-state: capture on accept, one running compare per SCAN cycle.
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    idx_d      = idx_q;
`ifdef ARGMAX_MARGIN_EN
    second_d   = second_q;
`endif
    cur        = cap_q[idx_q];
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          cap_d      = logits_i;
          best_val_d = logits_i[0];
          best_idx_d = '0;
          idx_d      = IDX_WIDTH'(1);
`ifdef ARGMAX_MARGIN_EN
          second_d   = MINV;
`endif
          state_d    = (N_NEURONS == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (cur > best_val_q) begin
          best_val_d = cur;
          best_idx_d = idx_q;
`ifdef ARGMAX_MARGIN_EN
          second_d   = best_val_q;
        end else if (cur > second_q) begin
          second_d   = cur;
`endif
        end
        idx_d = idx_q + IDX_WIDTH'(1);
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      for (int i = 0; i < N_NEURONS; i++) cap_q[i] <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_q   <= MINV;
`endif
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      idx_q      <= idx_d;
`ifdef ARGMAX_MARGIN_EN
      second_q   <= second_d;
`endif
    end
  end

`ifdef ARGMAX_MARGIN_EN
  // Margin is non-negative; saturate when it overflows DATA_WIDTH.
  always_comb begin
    diff = {best_val_q[DATA_WIDTH-1], best_val_q}
         - {second_q[DATA_WIDTH-1], second_q};
    sat  = diff[DATA_WIDTH-1:0];
    if (diff[DATA_WIDTH] ^ diff[DATA_WIDTH-1]) sat = MAXV;
    if (N_NEURONS == 1) sat = MAXV;
    margin_o = (state_q == DONE) ? sat : '0;
  end
`endif

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign class_o     = best_idx_q;
  assign max_logit_o = best_val_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier (default N_NEURONS=10).
// Build with +define+ARGMAX_MARGIN_EN to cover margin_o as well.
module tb_argmax_classifier;

  localparam int N = 10;
  typedef logic signed [31:0] vec_t [N];
  typedef struct {
    logic        [3:0]  cls;
    logic signed [31:0] val;
    logic signed [31:0] mar;
  } exp_t;

  logic              clk_i = 0;
  logic              rst_ni;
  vec_t              logits_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic        [3:0] class_o;
  logic signed [31:0] max_logit_o;
  logic signed [31:0] margin_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              busy_o;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  always #5 clk_i = ~clk_i;

  argmax_classifier dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .logits_i    (logits_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .class_o     (class_o),
    .max_logit_o (max_logit_o),
`ifdef ARGMAX_MARGIN_EN
    .margin_o    (margin_o),
`endif
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

`ifndef ARGMAX_MARGIN_EN
  assign margin_o = '0;
`endif

  function automatic exp_t model(input vec_t v);
    exp_t e;
    logic signed [31:0] b, s;
    logic signed [32:0] d;
    b = v[0];
    s = 32'sh8000_0000;
    e.cls = 0;
    for (int i = 1; i < N; i++) begin
      if (v[i] > b) begin
        s = b; b = v[i]; e.cls = 4'(i);
      end else if (v[i] > s) begin
        s = v[i];
      end
    end
    e.val = b;
    d = 33'(b) - 33'(s);
    e.mar = (d > 33'sh0_7FFF_FFFF) ? 32'sh7FFF_FFFF : d[31:0];
    return e;
  endfunction

  task automatic send(input vec_t v, input bit push);
    @(negedge clk_i);
    logits_i = v;
    in_valid_i = 1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got %b want 1", in_ready_o);
    end
    if (push) q.push_back(model(v));
    @(posedge clk_i);
    #1 in_valid_i = 0;
  endtask

  task automatic wait_result(input bit hs);
    int n;
    exp_t e;
    n = 0;
    while (n < 40 && out_valid_o !== 1'b1) begin
      @(posedge clk_i); #1;
      n++;
    end
    checks++;
    if (n != N - 1) begin
      errors++;
      $display("FAIL latency got %0d want %0d", n, N - 1);
    end
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty got 0 want 1");
    end else begin
      e = q.pop_front();
      checks++;
      if (class_o !== e.cls) begin
        errors++;
        $display("FAIL class got %0d want %0d", class_o, e.cls);
      end
      checks++;
      if (max_logit_o !== e.val) begin
        errors++;
        $display("FAIL max_logit got %h want %h", max_logit_o, e.val);
      end
`ifdef ARGMAX_MARGIN_EN
      checks++;
      if (margin_o !== e.mar) begin
        errors++;
        $display("FAIL margin got %h want %h", margin_o, e.mar);
      end
`endif
    end
    if (hs) begin
      @(posedge clk_i); #1;
      checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL post_hs got v=%b r=%b want v=0 r=1",
                 out_valid_o, in_ready_o);
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 0; in_valid_i = 0; out_ready_i = 1;
    for (int i = 0; i < N; i++) logits_i[i] = 0;
    #1;
    checks++;
    if (in_ready_o !== 1 || out_valid_o !== 0 || busy_o !== 0 ||
        class_o !== 0 || max_logit_o !== 0 || margin_o !== 0) begin
      errors++;
      $display("FAIL reset got r=%b v=%b b=%b c=%0d m=%h g=%h want 1 0 0 0 0 0",
               in_ready_o, out_valid_o, busy_o, class_o, max_logit_o, margin_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_single();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = 32'hFFFF_0000;
    v[3] = 32'h0001_0000;
    send(v, 1);
    wait_result(1);
  endtask

  task automatic test_tie();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = 0;
    v[2] = 32'h0002_0000;
    v[7] = 32'h0002_0000;
    send(v, 1);
    logits_i[7] = 32'h0100_0000;
    wait_result(1);
  endtask

  task automatic test_negative();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = 32'hF000_0000 + 32'(i);
    v[0] = 32'h8000_0000;
    v[9] = 32'hFFFF_FFFF;
    send(v, 1);
    wait_result(1);
  endtask

  task automatic test_random();
    vec_t v;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++)
        v[i] = (k < 3) ? 32'($signed(4'($urandom_range(0, 15))))
                       : 32'($urandom);
      send(v, 1);
      wait_result(1);
    end
  endtask

  task automatic test_back_to_back();
    vec_t a, b;
    exp_t held;
    for (int i = 0; i < N; i++) begin
      a[i] = 32'(i * 3);
      b[i] = 32'(100 - i * 7);
    end
    a[5] = 32'h0000_7000;
    b[8] = 32'h0004_0000;
    out_ready_i = 0;
    send(a, 1);
    held = model(a);
    wait_result(0);
    logits_i = b;
    in_valid_i = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      checks++;
      if (out_valid_o !== 1 || in_ready_o !== 0 ||
          class_o !== held.cls || max_logit_o !== held.val) begin
        errors++;
        $display("FAIL hold c=%0d got v=%b r=%b cls=%0d m=%h want 1 0 %0d %h",
                 c, out_valid_o, in_ready_o, class_o, max_logit_o,
                 held.cls, held.val);
      end
    end
    out_ready_i = 1;
    @(posedge clk_i); #1;
    checks++;
    if (out_valid_o !== 0 || in_ready_o !== 1) begin
      errors++;
      $display("FAIL release got v=%b r=%b want 0 1",
               out_valid_o, in_ready_o);
    end
    q.push_back(model(b));
    @(posedge clk_i);
    #1 in_valid_i = 0;
    checks++;
    if (busy_o !== 1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b want 1", busy_o);
    end
    wait_result(1);
  endtask

  task automatic test_reset_mid_scan();
    vec_t v;
    int seen;
    for (int i = 0; i < N; i++) v[i] = 32'(i + 1);
    send(v, 0);
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 0;
    #1;
    checks++;
    if (in_ready_o !== 1 || out_valid_o !== 0 || busy_o !== 0 ||
        class_o !== 0 || max_logit_o !== 0 || margin_o !== 0) begin
      errors++;
      $display("FAIL mid_reset got r=%b v=%b b=%b c=%0d m=%h want 1 0 0 0 0",
               in_ready_o, out_valid_o, busy_o, class_o, max_logit_o);
    end
    @(negedge clk_i);
    rst_ni = 1;
    seen = 0;
    repeat (15) begin
      @(negedge clk_i);
      if (out_valid_o === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_reset_emit got %0d want 0", seen);
    end
  endtask

`ifdef ARGMAX_MARGIN_EN
  task automatic test_margin();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = 32'h8000_0000;
    v[4] = 32'h7FFF_FFFF;
    send(v, 1);
    wait_result(0);
    checks++;
    if (margin_o !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL margin_sat got %h want 7fffffff", margin_o);
    end
    @(posedge clk_i); #1;
    for (int i = 0; i < N; i++) v[i] = 32'hFFFF_0000;
    v[1] = 32'h0003_0000;
    v[6] = 32'h0001_0000;
    send(v, 1);
    wait_result(0);
    checks++;
    if (margin_o !== 32'h0002_0000) begin
      errors++;
      $display("FAIL margin_diff got %h want 00020000", margin_o);
    end
    @(posedge clk_i); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_negative();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef ARGMAX_MARGIN_EN
    test_margin();
`endif
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
